// File: rtl/rca_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rca_pipe
// Description : Pipelined ripple-carry adder. The WIDTH-bit add is split into
//               STAGES chunks, and each stage registers the carry that feeds
//               the next stage. Optional signed overflow is controlled by the
//               macro RCA_PIPE_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int C_CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("rca_pipe: WIDTH must be a positive multiple of STAGES, with 1 <= STAGES <= WIDTH");
    end

    // All stages move together: the pipe advances whenever the output slot frees up.
    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // C_REM is the count of operand bits that are not yet added when this stage is entered.
        localparam int C_REM = WIDTH - k * C_CHUNK;
        localparam int C_SUM = (k + 1) * C_CHUNK;

        logic [C_REM-1:0]   w_rem_a;
        logic [C_REM-1:0]   w_rem_b;
        logic               w_cin;
        logic               w_vin;
        logic [C_CHUNK-1:0] w_s;
        logic               w_cout;
        logic [C_SUM-1:0]   w_sum_nxt;

        logic [C_SUM-1:0]   r_sum;
        logic               r_cy;
        logic               r_vld;

        if (k == 0) begin : g_head
            assign w_rem_a   = in_a;
            assign w_rem_b   = in_b;
            assign w_cin     = in_cin;
            assign w_vin     = in_valid;
            assign w_sum_nxt = w_s;
        end else begin : g_body
            assign w_rem_a   = g_stage[k-1].g_fwd.r_ua;
            assign w_rem_b   = g_stage[k-1].g_fwd.r_ub;
            assign w_cin     = g_stage[k-1].r_cy;
            assign w_vin     = g_stage[k-1].r_vld;
            assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
        end

        // Full-adder chain over this stage's chunk.
        always_comb begin
            logic v_c;
            v_c = w_cin;
            w_s = '0;
            for (int i = 0; i < C_CHUNK; i++) begin
                w_s[i] = w_rem_a[i] ^ w_rem_b[i] ^ v_c;
                v_c    = (w_rem_a[i] & w_rem_b[i]) | (v_c & (w_rem_a[i] ^ w_rem_b[i]));
            end
            w_cout = v_c;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_cy  <= w_cout;
                r_sum <= w_sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [C_REM-C_CHUNK-1:0] r_ua;
            logic [C_REM-C_CHUNK-1:0] r_ub;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ua <= '0;
                    r_ub <= '0;
                end else if (w_adv) begin
                    r_ua <= w_rem_a[C_REM-1:C_CHUNK];
                    r_ub <= w_rem_b[C_REM-1:C_CHUNK];
                end
            end
        end

`ifdef RCA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // The carry into the MSB is recovered as a^b^s at that bit.
            logic w_cmsb;
            logic r_ovf;
            assign w_cmsb = w_rem_a[C_CHUNK-1] ^ w_rem_b[C_CHUNK-1] ^ w_s[C_CHUNK-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_cmsb ^ w_cout;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign out_sum   = g_stage[STAGES-1].r_sum;
    assign out_cout  = g_stage[STAGES-1].r_cy;

`ifdef RCA_PIPE_OVF_EN
    assign out_ovf = g_stage[STAGES-1].g_ovf.r_ovf;
`else
    assign out_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rca_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rca_pipe
// Description : Self-checking bench for rca_pipe. It runs a 16/4 directed
//               table and directed sequences, then random traffic on the
//               32/1, 32/8 and 8/8 configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_pipe;

`ifdef RCA_PIPE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers. Result is packed as {ovf, cout, sum[31:0]}.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin);
        longint unsigned m, ua, ub, tot;
        longint sa, sb, ss;
        logic ovf;
        m   = 64'd1 << w;
        ua  = a & (m - 1);
        ub  = b & (m - 1);
        tot = ua + ub + 64'(cin);
        sa  = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
        sb  = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
        ss  = sa + sb + longint'(cin);
        ovf = (ss >= longint'(m / 2)) || (ss < -longint'(m / 2));
        model = (tot % m) | (((tot / m) & 64'd1) << 32) | (64'(OVF_ON & ovf) << 33);
    endfunction

    function automatic logic [63:0] pack(input logic [31:0] sum, input logic cout, input logic ovf);
        pack = 64'(sum) | (64'(cout) << 32) | (64'(ovf) << 33);
    endfunction

    // ------------------------------------------------------------------ main DUT 16/4
    logic         rst, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] in_a, in_b, out_sum;

    rca_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 11;
    vec_t tbl [NVEC];

    logic [15:0] sa [16];
    logic [15:0] sb [16];
    logic        sc [16];

    // One operand pair into an empty pipe; returns cycles to result and the result. Drains it afterwards.
    task automatic single_beat(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               output int lat, output logic [15:0] s, output logic c, output logic o);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = out_sum;
        c = out_cout;
        o = out_ovf;
        @(negedge clk);
    endtask

    // Streams n pairs from sa/sb/sc with out_ready low for stall_len cycles starting at cycle stall_from.
    task automatic run_stream(input int n, input int stall_from, input int stall_len, input string tag);
        logic [63:0] exp_q[$];
        logic [15:0] hold_sum;
        logic        hold_cout;
        logic        hold_v;
        int idx, got, t, first, last;
        idx = 0; got = 0; t = 0; first = -1; last = -1; hold_v = 1'b0;
        hold_sum = '0; hold_cout = 1'b0;
        while (got < n && t < 200) begin
            out_ready = !(t >= stall_from && t < stall_from + stall_len);
            if (idx < n) begin
                in_valid = 1'b1; in_a = sa[idx]; in_b = sb[idx]; in_cin = sc[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold_v) begin
                check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_hold_sum"}, 64'(out_sum), 64'(hold_sum));
                check({tag, "_hold_cout"}, 64'(out_cout), 64'(hold_cout));
            end
            if (stall_len == 0 && idx < n) check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            if (!out_ready && out_valid) check({tag, "_in_ready_stall"}, 64'(in_ready), 64'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious_valid"}, 64'd1, 64'd0);
                end else begin
                    check({tag, "_result"}, pack(32'(out_sum), out_cout, out_ovf), exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                        if (first < 0) first = t;
                        last = t;
                    end
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_sum  = out_sum;
            hold_cout = out_cout;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(16, 32'(sa[idx]), 32'(sb[idx]), sc[idx]));
                idx++;
            end
            @(negedge clk);
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(n));
        if (stall_len == 0) begin
            check({tag, "_first_latency"}, 64'(first), 64'(S));
            check({tag, "_back_to_back"}, 64'(last - first), 64'(n - 1));
        end
    endtask

    initial begin
        int          lat, stale, guard;
        logic [15:0] s;
        logic        c, o;

        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[5]  = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
        tbl[6]  = '{16'h0FFF, 16'hF001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        tbl[10] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        for (int i = 0; i < NVEC; i++) begin
            single_beat(tbl[i].a, tbl[i].b, tbl[i].cin, lat, s, c, o);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
            check($sformatf("vec%0d_sum", i), 64'(s), 64'(tbl[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(c), 64'(tbl[i].cout));
            check($sformatf("vec%0d_ovf", i), 64'(o), 64'(tbl[i].ovf & OVF_ON));
        end

        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'(i * 16'h1111);
            sb[i] = 16'h0F0F;
            sc[i] = 1'(i & 1);
        end
        run_stream(8, 1000, 0, "stream");

        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            sc[i] = 1'($urandom_range(0, 1));
        end
        run_stream(8, 5, 5, "stall");

        // Reset with three operations in flight, the oldest presented and held at the output.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'h1234 + 16'(i); in_b = 16'h1111; in_cin = 1'b0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_sum", 64'(out_sum), 64'h2345);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        check("midrst_out_cout", 64'(out_cout), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            @(negedge clk);
        end
        check("post_rst_no_stale", 64'(stale), 64'd0);

        guard = 0;
        while (!(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f) && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        check("random_configs_done",
              64'({g_rnd[0].done_f, g_rnd[1].done_f, g_rnd[2].done_f}), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ------------------------------------------------------------------ random configurations
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int RW = (g == 2) ? 8 : 32;
        localparam int RS = (g == 0) ? 1 : 8;
        localparam int NPAIRS = 1000;

        logic          rst_g, iv, ir, cin_g, ov, ordy, co, of;
        logic [RW-1:0] a_g, b_g, s_g;
        bit            done_f = 1'b0;

        rca_pipe #(.WIDTH(RW), .STAGES(RS)) u_dut (
            .clk(clk), .rst(rst_g), .in_valid(iv), .in_ready(ir),
            .in_a(a_g), .in_b(b_g), .in_cin(cin_g),
            .out_valid(ov), .out_ready(ordy),
            .out_sum(s_g), .out_cout(co), .out_ovf(of)
        );

        initial begin
            logic [63:0] q[$];
            logic [63:0] exp_v;
            int lat, sent, got, cyc;
            string tag;
            tag = $sformatf("cfg%0d_%0d", RW, RS);

            rst_g = 1'b1; iv = 1'b0; a_g = '0; b_g = '0; cin_g = 1'b0; ordy = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check({tag, "_rst_valid"}, 64'(ov), 64'd0);
            rst_g = 1'b0;
            @(negedge clk);

            iv = 1'b1; a_g = RW'($urandom); b_g = RW'($urandom); cin_g = 1'b1;
            exp_v = model(RW, 32'(a_g), 32'(b_g), cin_g);
            @(negedge clk);
            iv = 1'b0;
            lat = 1;
            while (!ov && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check({tag, "_latency"}, 64'(lat), 64'(RS));
            check({tag, "_lat_result"}, pack(32'(s_g), co, of), exp_v);
            @(negedge clk);

            sent = 0; got = 0; cyc = 0;
            while (got < NPAIRS && cyc < 20000) begin
                ordy = ($urandom_range(0, 3) != 0);
                if (sent < NPAIRS && $urandom_range(0, 4) != 0) begin
                    iv = 1'b1; a_g = RW'($urandom); b_g = RW'($urandom); cin_g = 1'($urandom_range(0, 1));
                end else begin
                    iv = 1'b0;
                end
                #1;
                if (ov) begin
                    if (q.size() == 0) begin
                        check({tag, "_spurious_valid"}, 64'd1, 64'd0);
                    end else begin
                        check({tag, "_result"}, pack(32'(s_g), co, of), q[0]);
                        if (ordy) begin
                            void'(q.pop_front());
                            got++;
                        end
                    end
                end
                if (iv && ir) begin
                    q.push_back(model(RW, 32'(a_g), 32'(b_g), cin_g));
                    sent++;
                end
                @(negedge clk);
                cyc++;
            end
            iv = 1'b0;
            ordy = 1'b1;
            check({tag, "_count"}, 64'(got), 64'(NPAIRS));
            done_f = 1'b1;
        end
    end

endmodule
`default_nettype wire
